serial_adder_ctrl: RTL and testbench

Bit-serial add/subtract engine. One 1-bit full-adder slice plus a carry flip-flop is time-shared across all operand bits, and this controller sequences the slice. Operand pairs are accepted over a valid/ready handshake, processed LSB-first for WIDTH cycles, and returned over a second valid/ready handshake. It is the area-minimal alternative to a ripple-carry adder chain, for low-throughput datapaths.

---
 rtl/serial_adder_ctrl.sv | 95 +++++++++
 tb/tb_serial_adder_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract: one full-adder slice plus carry flop, sequenced LSB-first over WIDTH cycles.
// Latency WIDTH cycles accept-to-out_valid; result held in DONE until out_ready, in_ready low outside IDLE.
module serial_adder_ctrl #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             overflow
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_MSB_CIN = CNT_W'(WIDTH - 2);

   logic [1:0]       state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] sum_sr;
   logic [CNT_W-1:0] count;
   logic             carry_ff;
   logic             msb_cin;
   logic             s;
   logic             c;

   assign s = a_sr[0] ^ b_sr[0] ^ carry_ff;
   assign c = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry_ff) | (b_sr[0] & carry_ff);

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         a_sr      <= '0;
         b_sr      <= '0;
         sum_sr    <= '0;
         count     <= '0;
         carry_ff  <= 1'b0;
         msb_cin   <= 1'b0;
         sum       <= '0;
         carry_out <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  // Subtract is A + ~B + 1: the +1 enters as the initial carry.
                  a_sr     <= a;
                  b_sr     <= sub ? ~b : b;
                  carry_ff <= sub;
                  count    <= '0;
                  sum_sr   <= '0;
                  state    <= RUN;
               end
            end
            RUN: begin
               sum_sr   <= {s, sum_sr[WIDTH-1:1]};
               a_sr     <= {1'b0, a_sr[WIDTH-1:1]};
               b_sr     <= {1'b0, b_sr[WIDTH-1:1]};
               carry_ff <= c;
               count    <= count + CNT_W'(1);
               if (count == CNT_MSB_CIN) begin
                  msb_cin <= c;
               end
               if (count == CNT_LAST) begin
                  sum       <= {s, sum_sr[WIDTH-1:1]};
                  carry_out <= c;
                  overflow  <= msb_cin ^ c;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: directed cases on WIDTH=8, then randomized back-to-back runs on WIDTH 8, 2 and 16.
module tb_serial_adder_ctrl;

   typedef struct packed {
      logic [63:0] sum;
      logic        co;
      logic        ov;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        out_ready;
   logic [63:0] a_in;
   logic [63:0] b_in;
   logic        sub_in;
   int          sel;

   int checks   = 0;
   int failures = 0;
   exp_t q[$];

   logic        rdy8, vld8, co8, ov8;
   logic [7:0]  sum8;
   logic        rdy2, vld2, co2, ov2;
   logic [1:0]  sum2;
   logic        rdy16, vld16, co16, ov16;
   logic [15:0] sum16;

   logic        obs_in_ready, obs_out_valid, obs_co, obs_ov;
   logic [63:0] obs_sum;

   always #5 clk = ~clk;

   serial_adder_ctrl #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid && (sel == 8)), .in_ready(rdy8),
      .a(a_in[7:0]), .b(b_in[7:0]), .sub(sub_in), .out_valid(vld8), .out_ready(out_ready),
      .sum(sum8), .carry_out(co8), .overflow(ov8));

   serial_adder_ctrl #(.WIDTH(2)) dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid && (sel == 2)), .in_ready(rdy2),
      .a(a_in[1:0]), .b(b_in[1:0]), .sub(sub_in), .out_valid(vld2), .out_ready(out_ready),
      .sum(sum2), .carry_out(co2), .overflow(ov2));

   serial_adder_ctrl #(.WIDTH(16)) dut16 (
      .clk(clk), .rst(rst), .in_valid(in_valid && (sel == 16)), .in_ready(rdy16),
      .a(a_in[15:0]), .b(b_in[15:0]), .sub(sub_in), .out_valid(vld16), .out_ready(out_ready),
      .sum(sum16), .carry_out(co16), .overflow(ov16));

   assign obs_in_ready  = (sel == 2) ? rdy2 : (sel == 16) ? rdy16 : rdy8;
   assign obs_out_valid = (sel == 2) ? vld2 : (sel == 16) ? vld16 : vld8;
   assign obs_co        = (sel == 2) ? co2  : (sel == 16) ? co16  : co8;
   assign obs_ov        = (sel == 2) ? ov2  : (sel == 16) ? ov16  : ov8;
   assign obs_sum       = (sel == 2) ? 64'(sum2) : (sel == 16) ? 64'(sum16) : 64'(sum8);

   // Reference: plain integer add, signed overflow from operand/result sign bits.
   function automatic exp_t model(input int w, input logic [63:0] av, input logic [63:0] bv,
                                  input logic sv);
      exp_t        e;
      logic [63:0] mask;
      logic [63:0] am;
      logic [63:0] bm;
      logic [64:0] r;
      mask   = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
      am     = av & mask;
      bm     = (sv ? ~bv : bv) & mask;
      r      = {1'b0, am} + {1'b0, bm} + 65'(sv);
      e.sum  = r[63:0] & mask;
      e.co   = r[w];
      e.ov   = (am[w-1] == bm[w-1]) && (e.sum[w-1] != am[w-1]);
      return e;
   endfunction

   function automatic exp_t mk(input logic [63:0] s, input logic co, input logic ov);
      exp_t e;
      e.sum = s;
      e.co  = co;
      e.ov  = ov;
      return e;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s w=%0d observed=%0h expected=%0h", tag, sel, obs, exp);
      end
   endtask

   // Called just after a negedge; returns #1 after the accepting posedge.
   task automatic send(input logic [63:0] av, input logic [63:0] bv, input logic sv,
                       input exp_t e);
      a_in     = av;
      b_in     = bv;
      sub_in   = sv;
      in_valid = 1'b1;
      chk("in_ready_at_accept", 64'(obs_in_ready), 64'd1);
      @(posedge clk);
      q.push_back(e);
      #1;
      in_valid = 1'b0;
      a_in     = ~av;
      b_in     = ~bv;
      sub_in   = ~sv;
   endtask

   // Counts posedges from accept until out_valid is seen, then compares against the scoreboard.
   task automatic collect(input int exp_lat);
      int   lat;
      exp_t e;
      lat = 0;
      @(negedge clk);
      while (!obs_out_valid && lat < 200) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      chk("latency", 64'(lat), 64'(exp_lat));
      if (q.size() == 0) begin
         chk("scoreboard_empty", 64'd1, 64'd0);
      end else begin
         e = q.pop_front();
         chk("sum", obs_sum, e.sum);
         chk("carry_out", 64'(obs_co), 64'(e.co));
         chk("overflow", 64'(obs_ov), 64'(e.ov));
      end
   endtask

   task automatic drain();
      @(posedge clk);
      @(negedge clk);
      chk("out_valid_drop", 64'(obs_out_valid), 64'd0);
      chk("in_ready_after_drop", 64'(obs_in_ready), 64'd1);
   endtask

   initial begin
      logic seen;
      rst       = 1'b1;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      sel       = 8;
      a_in      = 64'h12;
      b_in      = 64'h34;
      sub_in    = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_in_ready", 64'(obs_in_ready), 64'd1);
      chk("reset_out_valid", 64'(obs_out_valid), 64'd0);
      chk("reset_sum", obs_sum, 64'd0);
      chk("reset_carry", 64'(obs_co), 64'd0);
      chk("reset_overflow", 64'(obs_ov), 64'd0);
      rst      = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);

      out_ready = 1'b1;
      send(64'h0F, 64'h01, 1'b0, mk(64'h10, 1'b0, 1'b0)); collect(8); drain();
      send(64'hFF, 64'h01, 1'b0, mk(64'h00, 1'b1, 1'b0)); collect(8); drain();
      send(64'h7F, 64'h01, 1'b0, mk(64'h80, 1'b0, 1'b1)); collect(8); drain();
      send(64'h05, 64'h07, 1'b1, mk(64'hFE, 1'b0, 1'b0)); collect(8); drain();
      send(64'h07, 64'h05, 1'b1, mk(64'h02, 1'b1, 1'b0)); collect(8); drain();
      send(64'h80, 64'h01, 1'b1, mk(64'h7F, 1'b1, 1'b1)); collect(8); drain();

      // Backpressure: result must hold while a new request waits and operands churn.
      out_ready = 1'b0;
      send(64'h12, 64'h34, 1'b0, mk(64'h46, 1'b0, 1'b0));
      collect(8);
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         a_in   = 64'($urandom);
         b_in   = 64'($urandom);
         sub_in = 1'(i);
         @(posedge clk);
         @(negedge clk);
         chk("bp_in_ready", 64'(obs_in_ready), 64'd0);
         chk("bp_out_valid", 64'(obs_out_valid), 64'd1);
         chk("bp_sum_stable", obs_sum, 64'h46);
      end
      a_in      = 64'h21;
      b_in      = 64'h11;
      sub_in    = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("bp_out_valid_drop", 64'(obs_out_valid), 64'd0);
      chk("bp_in_ready_back", 64'(obs_in_ready), 64'd1);
      q.push_back(mk(64'h10, 1'b1, 1'b0));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      collect(8);
      drain();

      // Reset abort on the third RUN cycle.
      a_in     = 64'hAA;
      b_in     = 64'h55;
      sub_in   = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("abort_in_ready", 64'(obs_in_ready), 64'd1);
      chk("abort_out_valid", 64'(obs_out_valid), 64'd0);
      chk("abort_sum", obs_sum, 64'd0);
      chk("abort_carry", 64'(obs_co), 64'd0);
      chk("abort_overflow", 64'(obs_ov), 64'd0);
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         seen = seen | obs_out_valid;
      end
      chk("abort_no_out_valid", 64'(seen), 64'd0);
      send(64'h03, 64'h04, 1'b0, mk(64'h07, 1'b0, 1'b0)); collect(8); drain();

      // Back-to-back random runs with out_ready tied high, per width.
      for (int wi = 0; wi < 3; wi++) begin
         sel = (wi == 0) ? 8 : (wi == 1) ? 2 : 16;
         @(negedge clk);
         for (int n = 0; n < 100; n++) begin
            logic [63:0] av;
            logic [63:0] bv;
            logic        sv;
            av = {32'($urandom), 32'($urandom)};
            bv = {32'($urandom), 32'($urandom)};
            sv = 1'($urandom_range(0, 1));
            send(av, bv, sv, model(sel, av, bv, sv));
            collect(sel);
            drain();
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
